// File: rtl/pwm_multicanal.sv
// Multi-channel PWM generator: one shared prescaler and period counter, per-channel duty.
// Duty and frequency level are stepped through shadow registers and applied at the period wrap.
module pwm_multicanal #(
    parameter int N_CANALES   = 4,
    parameter int ANCHO_CICLO = 4,
    parameter int N_FREC      = 8,
    parameter int DIV_BASE    = 64,
    localparam int CW = (N_CANALES > 1) ? $clog2(N_CANALES) : 1,
    localparam int FW = $clog2(N_FREC)
) (
    input  logic                   clk_i,
    input  logic                   reset,
    input  logic                   en_i,
    input  logic [CW-1:0]          canal_i,
    input  logic                   aumC_i,
    input  logic                   bajaC_i,
    input  logic                   aumf_i,
    input  logic                   bajaf_i,
    output logic [N_CANALES-1:0]   pwm_o,
    output logic [ANCHO_CICLO-1:0] valueC_o,
    output logic [FW-1:0]          valueF_o,
    output logic                   fin_periodo_o
);
    localparam int MAX_DIV = DIV_BASE << (N_FREC - 1);
    localparam int PW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam logic [ANCHO_CICLO-1:0] DUTY_MAX = {ANCHO_CICLO{1'b1}};
    localparam logic [ANCHO_CICLO-1:0] CNT_LAST = {{(ANCHO_CICLO-1){1'b1}}, 1'b0};
    localparam logic [FW-1:0]          FREC_MAX = FW'(N_FREC - 1);

    logic                   aumc_q, bajac_q, aumf_q, bajaf_q;
    logic [PW-1:0]          presc_q, presc_d;
    logic [ANCHO_CICLO-1:0] cnt_q, cnt_d;
    logic [FW-1:0]          frec_sh_q, frec_sh_d, frec_act_q, frec_act_d;
    logic [ANCHO_CICLO-1:0] duty_sh_q [N_CANALES];
    logic [ANCHO_CICLO-1:0] duty_sh_d [N_CANALES];
    logic [ANCHO_CICLO-1:0] duty_act_q [N_CANALES];
    logic [ANCHO_CICLO-1:0] duty_act_d [N_CANALES];
    logic [N_CANALES-1:0]   pwm_q, pwm_d;
    logic                   fin_q, fin_d;

    logic                   aumc_ev_s, bajac_ev_s, aumf_ev_s, bajaf_ev_s;
    logic                   canal_ok_s, tick_s, wrap_s;
    logic [PW:0]            div_s;
    logic [PW-1:0]          div_m1_s;
    logic [ANCHO_CICLO-1:0] valuec_s;

    // Request edges, divisor for the active level, tick and period wrap.
    always_comb begin
        aumc_ev_s  = aumC_i & ~aumc_q;
        bajac_ev_s = bajaC_i & ~bajac_q;
        aumf_ev_s  = aumf_i & ~aumf_q;
        bajaf_ev_s = bajaf_i & ~bajaf_q;
        canal_ok_s = (int'(canal_i) < N_CANALES);
        div_s      = (PW+1)'(DIV_BASE) << (FREC_MAX - frec_act_q);
        div_m1_s   = PW'(div_s - (PW+1)'(1));
        tick_s     = en_i & (presc_q == div_m1_s);
        wrap_s     = tick_s & (cnt_q == CNT_LAST);
    end

    // Prescaler, period counter and frequency level shadow/active next state.
    always_comb begin
        presc_d    = presc_q;
        cnt_d      = cnt_q;
        frec_sh_d  = frec_sh_q;
        frec_act_d = frec_act_q;
        fin_d      = wrap_s;
        if (en_i) begin
            if (tick_s) begin
                presc_d = '0;
                cnt_d   = wrap_s ? '0 : cnt_q + ANCHO_CICLO'(1);
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = presc_q;
        end
        // The wrap latches the shadow as it was before any event on this clock.
        if (wrap_s) begin
            frec_act_d = frec_sh_q;
        end else begin
            frec_act_d = frec_act_q;
        end
        if (aumf_ev_s && !bajaf_ev_s && (frec_sh_q != FREC_MAX)) begin
            frec_sh_d = frec_sh_q + FW'(1);
        end else if (bajaf_ev_s && !aumf_ev_s && (frec_sh_q != '0)) begin
            frec_sh_d = frec_sh_q - FW'(1);
        end else begin
            frec_sh_d = frec_sh_q;
        end
    end

    // Per-channel duty shadow/active next state, PWM compare and display read-back.
    always_comb begin
        pwm_d    = '0;
        valuec_s = '0;
        for (int k = 0; k < N_CANALES; k++) begin
            duty_sh_d[k]  = duty_sh_q[k];
            duty_act_d[k] = wrap_s ? duty_sh_q[k] : duty_act_q[k];
            pwm_d[k]      = en_i & (cnt_q < duty_act_q[k]);
            if (canal_ok_s && (CW'(k) == canal_i)) begin
                valuec_s = duty_sh_q[k];
                if (aumc_ev_s && !bajac_ev_s && (duty_sh_q[k] != DUTY_MAX)) begin
                    duty_sh_d[k] = duty_sh_q[k] + ANCHO_CICLO'(1);
                end else if (bajac_ev_s && !aumc_ev_s && (duty_sh_q[k] != '0)) begin
                    duty_sh_d[k] = duty_sh_q[k] - ANCHO_CICLO'(1);
                end else begin
                    duty_sh_d[k] = duty_sh_q[k];
                end
            end else begin
                duty_sh_d[k] = duty_sh_q[k];
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            aumc_q     <= 1'b0;
            bajac_q    <= 1'b0;
            aumf_q     <= 1'b0;
            bajaf_q    <= 1'b0;
            presc_q    <= '0;
            cnt_q      <= '0;
            frec_sh_q  <= '0;
            frec_act_q <= '0;
            pwm_q      <= '0;
            fin_q      <= 1'b0;
            for (int k = 0; k < N_CANALES; k++) begin
                duty_sh_q[k]  <= '0;
                duty_act_q[k] <= '0;
            end
        end else begin
            aumc_q     <= aumC_i;
            bajac_q    <= bajaC_i;
            aumf_q     <= aumf_i;
            bajaf_q    <= bajaf_i;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            frec_sh_q  <= frec_sh_d;
            frec_act_q <= frec_act_d;
            pwm_q      <= pwm_d;
            fin_q      <= fin_d;
            for (int k = 0; k < N_CANALES; k++) begin
                duty_sh_q[k]  <= duty_sh_d[k];
                duty_act_q[k] <= duty_act_d[k];
            end
        end
    end

    assign pwm_o         = pwm_q;
    assign fin_periodo_o = fin_q;
    assign valueC_o      = valuec_s;
    assign valueF_o      = frec_sh_q;

endmodule

// File: doc/pwm_multicanal.md
Name: pwm_multicanal

Overview:
Parametrised successor to the single-channel PWM path (frequency select + 4-bit duty reference). Generates N_CANALES independent PWM outputs sharing one period counter and a selectable frequency level. Duty and frequency are stepped by up/down pulse inputs from the main button controller. New settings are held in shadow registers and applied only at a period boundary, so outputs never glitch. Current values are exported for the 7-segment display controller.

Parameters:
N_CANALES, 4, number of PWM channels (1..16)
ANCHO_CICLO, 4, duty resolution W; period = 2^W-1 ticks, duty range 0..2^W-1 (0%..100%)
N_FREC, 8, number of frequency levels (power of two, 2..16)
DIV_BASE, 64, clocks per tick at the highest frequency level (>=1)

Ports:
clk_i  in  1  system clock
reset  in  1  asynchronous, active-high reset
en_i  in  1  run enable; low freezes prescaler and period counter
canal_i  in  clog2(N_CANALES) (min 1)  channel addressed by duty up/down
aumC_i  in  1  duty up request (level; rising edge acts)
bajaC_i  in  1  duty down request (level; rising edge acts)
aumf_i  in  1  frequency level up request (rising edge acts)
bajaf_i  in  1  frequency level down request (rising edge acts)
pwm_o  out  N_CANALES  PWM outputs, registered
valueC_o  out  ANCHO_CICLO  shadow duty of channel canal_i
valueF_o  out  clog2(N_FREC)  shadow frequency level
fin_periodo_o  out  1  one-clock pulse on period wrap

Behaviour:
- Reset (async, immediate): pwm_o=0, all duty (shadow and active)=0, frequency level (shadow and active)=0, prescaler=0, period counter=0, edge registers=0, fin_periodo_o=0, valueC_o=0, valueF_o=0.
- Edge detect: each request input registered once; event = in & ~in_q. Shadow register updates on the clock the event is detected. A level held high produces one event only.
- Duty step: aumC event -> shadow duty[canal_i] +1, saturating at 2^W-1; bajaC event -> -1, saturating at 0. aumC and bajaC events in the same cycle: no change. Other channels untouched.
- Frequency step: aumf +1 saturating at N_FREC-1; bajaf -1 saturating at 0; simultaneous: no change.
- Divisor for active level f: DIV_BASE << (N_FREC-1-f); level 0 = slowest. Prescaler width sized internally for DIV_BASE<<(N_FREC-1).
- Prescaler counts 0..div-1 while en_i=1; tick when prescaler=div-1 (prescaler returns to 0).
- Period counter counts 0..2^W-2 on ticks; on tick at 2^W-2 it wraps to 0 and: fin_periodo_o=1 for that one clock; all active duties <= shadow duties; active level <= shadow level (new divisor applies from next prescaler cycle).
- Shadow event in the same cycle as a wrap: the wrap loads the pre-event shadow; the new value applies at the following wrap.
- pwm_o[k] <= en_i & (counter < active_duty[k]), one-clock latency from counter/duty. Duty 0 -> constant 0; duty 2^W-1 -> constant 1 while enabled.
- en_i=0: prescaler and counter hold, pwm_o=0 next clock, no wraps, requests still update shadows. en_i returning high resumes from held count.
- valueC_o/valueF_o are combinational reads of shadow registers (display shows the pending setting).
- canal_i >= N_CANALES: duty events ignored, valueC_o=0.

Test Plan:
- Reset mid-run with pwm_o high -> pwm_o=0, valueC_o=0, valueF_o=0 same cycle as reset assertion; counter restarts at 0 after release.
- W=4, DIV_BASE=2, N_FREC=2, level 0: 5 aumC events on ch0 -> after next wrap pwm_o[0] high 5 of 15 ticks, period 60 clocks; fin_periodo_o pulses every 60 clocks.
- 20 aumC events on ch1 -> valueC_o saturates at 15, pwm_o[1] constant 1; 20 bajaC -> 0, pwm_o[1] constant 0.
- aumf event mid-period -> valueF_o=1 immediately; period stays 60 clocks until wrap, then 30 clocks.
- aumC and bajaC rising same cycle -> shadow unchanged; aumC edge coinciding with wrap -> applied one period later.
- en_i low for 100 clocks -> pwm_o=0, no fin_periodo_o; en_i high -> counter resumes from held value.
